// File: rtl/ram_pkg.sv
// Shared definitions for the dual-port RAM: port A write-mode encodings
// and the zero-fill state machine encoding.
package ram_pkg;

    typedef enum int {
        WR_FIRST  = 0,
        RD_FIRST  = 1,
        NO_CHANGE = 2
    } write_mode_e;

    typedef logic [1:0] clr_state_t;

    localparam clr_state_t ST_IDLE  = 2'd0;
    localparam clr_state_t ST_CLEAR = 2'd1;
    localparam clr_state_t ST_READY = 2'd2;

endpackage

// File: rtl/ram_clear_fsm.sv
// Post-reset zero-fill sequencer: walks every address once, writing zero,
// and holds busy until the whole array has been cleared.
module ram_clear_fsm
    import ram_pkg::*;
#(
    parameter int ADDR_BITS      = 12,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    output logic                 busy,
    output logic                 clr_we,
    output logic [ADDR_BITS-1:0] clr_addr
);

    clr_state_t           state;
    logic [ADDR_BITS-1:0] count;

    // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state <= ST_IDLE;
            count <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
                    count <= '0;
                end
                ST_CLEAR: begin
                    if (&count) begin
                        state <= ST_READY;
                    end
                    count <= count + 1'b1;
                end
                ST_READY: state <= ST_READY;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    assign clr_we   = (state == ST_CLEAR);
    assign clr_addr = count;
    // Without a clear the array is usable straight out of reset.
    assign busy     = (CLEAR_ON_RESET != 0) && (state != ST_READY);

endmodule

// File: rtl/dual_port_ram.sv
// Single-clock RAM: port A read/write with byte enables, port B read-only,
// both with a 1- or 2-cycle registered read pipeline and a valid pulse.
module dual_port_ram
    import ram_pkg::*;
#(
    parameter int DATA_WIDTH     = 16,
    parameter int ADDR_BITS      = 12,
    parameter int READ_LATENCY   = 1,
    parameter int WRITE_MODE     = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic                    A_ENABLE,
    input  logic                    A_WRITE,
    input  logic [DATA_WIDTH/8-1:0] A_BYTE_EN,
    input  logic [15:0]             A_ADDR,
    input  logic [DATA_WIDTH-1:0]   A_DATA_IN,
    output logic [DATA_WIDTH-1:0]   A_DATA_OUT,
    output logic                    A_VALID,
    input  logic                    B_ENABLE,
    input  logic [15:0]             B_ADDR,
    output logic [DATA_WIDTH-1:0]   B_DATA_OUT,
    output logic                    B_VALID,
    output logic                    BUSY
);

    localparam int NUM_BYTES     = DATA_WIDTH / 8;
    localparam int DEPTH         = 1 << ADDR_BITS;
    localparam bit RETURN_MERGED = (WRITE_MODE == int'(WR_FIRST));
    localparam bit SILENT_WRITE  = (WRITE_MODE == int'(NO_CHANGE));

    logic                 clr_we;
    logic [ADDR_BITS-1:0] clr_addr;

    ram_clear_fsm #(
        .ADDR_BITS      (ADDR_BITS),
        .CLEAR_ON_RESET (CLEAR_ON_RESET)
    ) u_clear (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .busy     (BUSY),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    // Upper address bits are deliberately dropped so addresses wrap.
    logic [ADDR_BITS-1:0] a_idx;
    logic [ADDR_BITS-1:0] b_idx;
    logic                 unused_addr_bits;

    assign a_idx            = A_ADDR[ADDR_BITS-1:0];
    assign b_idx            = B_ADDR[ADDR_BITS-1:0];
    assign unused_addr_bits = ^{A_ADDR[15:ADDR_BITS], B_ADDR[15:ADDR_BITS]};

    logic a_acc;
    logic a_wr;
    logic b_acc;

    assign a_acc = A_ENABLE && !BUSY;
    assign a_wr  = a_acc && A_WRITE;
    assign b_acc = B_ENABLE && !BUSY;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // NOTE: the array has no reset branch; a reset would block RAM inference, so zeroing goes through the clear FSM.
    always_ff @(posedge CLK) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end else if (a_wr) begin
            for (int i = 0; i < NUM_BYTES; i++) begin
                if (A_BYTE_EN[i]) begin
                    mem[a_idx][8*i +: 8] <= A_DATA_IN[8*i +: 8];
                end
            end
        end
    end

    // Synchronous reads see the pre-write word, giving read-before-write on B.
    logic [DATA_WIDTH-1:0] a_raw;
    logic [DATA_WIDTH-1:0] b_raw;
    logic [DATA_WIDTH-1:0] a_wdata_q;
    logic [NUM_BYTES-1:0]  a_be_q;

    always_ff @(posedge CLK) begin
        if (a_acc) begin
            a_raw     <= mem[a_idx];
            a_wdata_q <= A_DATA_IN;
            a_be_q    <= A_BYTE_EN;
        end
        if (b_acc) begin
            b_raw <= mem[b_idx];
        end
    end

    logic a_s1_v;
    logic a_s1_w;
    logic b_s1_v;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            a_s1_v <= 1'b0;
            a_s1_w <= 1'b0;
            b_s1_v <= 1'b0;
        end else begin
            a_s1_v <= a_acc;
            a_s1_w <= a_wr;
            b_s1_v <= b_acc;
        end
    end

    logic [DATA_WIDTH-1:0] a_merged;
    logic [DATA_WIDTH-1:0] a_result;
    logic                  a_pulse;

    always_comb begin
        // NOTE: default assignment first, so no path leaves a_merged unassigned (no latch).
        a_merged = a_raw;
        for (int i = 0; i < NUM_BYTES; i++) begin
            if (a_be_q[i]) begin
                a_merged[8*i +: 8] = a_wdata_q[8*i +: 8];
            end
        end
    end

    assign a_result = (a_s1_w && RETURN_MERGED) ? a_merged : a_raw;
    assign a_pulse  = a_s1_v && !(a_s1_w && SILENT_WRITE);

    logic                  a_fin_v;
    logic                  b_fin_v;
    logic [DATA_WIDTH-1:0] a_fin_d;
    logic [DATA_WIDTH-1:0] b_fin_d;

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic                  a_v2;
            logic                  b_v2;
            logic [DATA_WIDTH-1:0] a_d2;
            logic [DATA_WIDTH-1:0] b_d2;

            always_ff @(posedge CLK) begin
                if (!RST_N) begin
                    a_v2 <= 1'b0;
                    b_v2 <= 1'b0;
                end else begin
                    a_v2 <= a_pulse;
                    b_v2 <= b_s1_v;
                end
            end

            always_ff @(posedge CLK) begin
                a_d2 <= a_result;
                b_d2 <= b_raw;
            end

            assign a_fin_v = a_v2;
            assign a_fin_d = a_d2;
            assign b_fin_v = b_v2;
            assign b_fin_d = b_d2;
        end else begin : g_lat1
            assign a_fin_v = a_pulse;
            assign a_fin_d = a_result;
            assign b_fin_v = b_s1_v;
            assign b_fin_d = b_raw;
        end
    endgenerate

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            A_DATA_OUT <= '0;
            A_VALID    <= 1'b0;
            B_DATA_OUT <= '0;
            B_VALID    <= 1'b0;
        end else begin
            A_VALID <= a_fin_v;
            B_VALID <= b_fin_v;
            if (a_fin_v) begin
                A_DATA_OUT <= a_fin_d;
            end
            if (b_fin_v) begin
                B_DATA_OUT <= b_fin_d;
            end
        end
    end

endmodule

// File: tb/tb_dual_port_ram.sv
// Bench for dual_port_ram: five 16-deep instances (latency 1 with modes 0/1/2,
// latency 2 with modes 0/1) share one stimulus and one array-level model.
module tb_dual_port_ram;

    localparam int NI = 5;

    logic        CLK;
    logic        RST_N;
    logic        A_ENABLE;
    logic        A_WRITE;
    logic [1:0]  A_BYTE_EN;
    logic [15:0] A_ADDR;
    logic [15:0] A_DATA_IN;
    logic        B_ENABLE;
    logic [15:0] B_ADDR;

    logic [15:0] a_dout  [NI];
    logic        a_valid [NI];
    logic [15:0] b_dout  [NI];
    logic        b_valid [NI];
    logic        busy    [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        dual_port_ram #(
            .DATA_WIDTH     (16),
            .ADDR_BITS      (4),
            .READ_LATENCY   ((g < 3) ? 1 : 2),
            .WRITE_MODE     ((g < 3) ? g : g - 3),
            .CLEAR_ON_RESET (1)
        ) u_dut (
            .CLK        (CLK),
            .RST_N      (RST_N),
            .A_ENABLE   (A_ENABLE),
            .A_WRITE    (A_WRITE),
            .A_BYTE_EN  (A_BYTE_EN),
            .A_ADDR     (A_ADDR),
            .A_DATA_IN  (A_DATA_IN),
            .A_DATA_OUT (a_dout[g]),
            .A_VALID    (a_valid[g]),
            .B_ENABLE   (B_ENABLE),
            .B_ADDR     (B_ADDR),
            .B_DATA_OUT (b_dout[g]),
            .B_VALID    (b_valid[g]),
            .BUSY       (busy[g])
        );
    end

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int lat_of(input int k);
        return (k < 3) ? 1 : 2;
    endfunction

    function automatic int mode_of(input int k);
        return (k < 3) ? k : k - 3;
    endfunction

    // Model: array contents, cycles since reset release, and a per-instance
    // schedule of results keyed by the edge at which they must appear.
    bit          started = 0;
    int          since   = 0;
    int unsigned edge_n  = 0;
    logic [15:0] mm [16];
    bit          pa_v [NI][4];
    logic [15:0] pa_d [NI][4];
    bit          pb_v [NI][4];
    logic [15:0] pb_d [NI][4];
    bit          ea_v [NI];
    logic [15:0] ea_d [NI];
    bit          eb_v [NI];
    logic [15:0] eb_d [NI];

    always @(posedge CLK) begin
        int          slot;
        int          due;
        bit          acc_a;
        bit          acc_b;
        logic [3:0]  ai;
        logic [3:0]  bi;
        logic [15:0] old_a;
        logic [15:0] old_b;
        logic [15:0] merged;
        edge_n++;
        slot = int'(edge_n % 4);
        if (!RST_N) begin
            started = 1;
            since   = 0;
            for (int k = 0; k < NI; k++) begin
                ea_v[k] = 0; ea_d[k] = 16'h0000;
                eb_v[k] = 0; eb_d[k] = 16'h0000;
                for (int s = 0; s < 4; s++) begin
                    pa_v[k][s] = 0;
                    pb_v[k][s] = 0;
                end
            end
        end else begin
            acc_a  = A_ENABLE && (since >= 17);
            acc_b  = B_ENABLE && (since >= 17);
            ai     = 4'(A_ADDR % 16'd16);
            bi     = 4'(B_ADDR % 16'd16);
            old_a  = mm[ai];
            old_b  = mm[bi];
            merged = old_a;
            if (A_BYTE_EN[0]) merged[7:0]  = A_DATA_IN[7:0];
            if (A_BYTE_EN[1]) merged[15:8] = A_DATA_IN[15:8];
            for (int k = 0; k < NI; k++) begin
                ea_v[k] = pa_v[k][slot];
                if (pa_v[k][slot]) ea_d[k] = pa_d[k][slot];
                pa_v[k][slot] = 0;
                eb_v[k] = pb_v[k][slot];
                if (pb_v[k][slot]) eb_d[k] = pb_d[k][slot];
                pb_v[k][slot] = 0;
                due = int'((edge_n + unsigned'(lat_of(k))) % 4);
                if (acc_a) begin
                    if (!A_WRITE)          begin pa_v[k][due] = 1; pa_d[k][due] = old_a;  end
                    else if (mode_of(k) == 0) begin pa_v[k][due] = 1; pa_d[k][due] = merged; end
                    else if (mode_of(k) == 1) begin pa_v[k][due] = 1; pa_d[k][due] = old_a;  end
                end
                if (acc_b) begin
                    pb_v[k][due] = 1;
                    pb_d[k][due] = old_b;
                end
            end
            if (acc_a && A_WRITE) mm[ai] = merged;
            if (since >= 1 && since <= 16) mm[4'(since - 1)] = 16'h0000;
            if (since < 17) since++;
        end
    end

    always @(negedge CLK) begin
        if (started) begin
            for (int k = 0; k < NI; k++) begin
                check($sformatf("a_data[%0d]", k), a_dout[k], ea_d[k]);
                check($sformatf("a_valid[%0d]", k), a_valid[k], ea_v[k]);
                check($sformatf("b_data[%0d]", k), b_dout[k], eb_d[k]);
                check($sformatf("b_valid[%0d]", k), b_valid[k], eb_v[k]);
                check($sformatf("busy[%0d]", k), busy[k], (since < 17) ? 1 : 0);
            end
        end
    end

    task automatic cyc();
        @(negedge CLK);
    endtask

    task automatic idle();
        A_ENABLE = 1'b0;
        A_WRITE  = 1'b0;
        B_ENABLE = 1'b0;
    endtask

    task automatic a_write(input logic [15:0] addr, input logic [15:0] data, input logic [1:0] be);
        A_ENABLE  = 1'b1;
        A_WRITE   = 1'b1;
        A_ADDR    = addr;
        A_DATA_IN = data;
        A_BYTE_EN = be;
    endtask

    task automatic a_read(input logic [15:0] addr);
        A_ENABLE = 1'b1;
        A_WRITE  = 1'b0;
        A_ADDR   = addr;
    endtask

    task automatic b_read(input logic [15:0] addr);
        B_ENABLE = 1'b1;
        B_ADDR   = addr;
    endtask

    // Release reset and count cycles with BUSY high; optionally hammer both
    // ports with a write/read of address 2 for as long as BUSY is high.
    task automatic release_and_count(input bit hold_access);
        int cnt [NI];
        bit any;
        for (int k = 0; k < NI; k++) cnt[k] = 0;
        RST_N = 1'b1;
        if (hold_access) begin
            a_write(16'h0002, 16'hBEEF, 2'b11);
            b_read(16'h0002);
        end
        for (int n = 0; n < 100; n++) begin
            any = 0;
            for (int k = 0; k < NI; k++) begin
                if (busy[k] === 1'b1) begin
                    cnt[k]++;
                    any = 1;
                end
            end
            if (!any) break;
            cyc();
        end
        idle();
        for (int k = 0; k < NI; k++) check($sformatf("busy_cycles[%0d]", k), cnt[k], 17);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RST_N     = 1'b0;
        A_ENABLE  = 1'b0;
        A_WRITE   = 1'b0;
        A_BYTE_EN = 2'b11;
        A_ADDR    = 16'h0000;
        A_DATA_IN = 16'h0000;
        B_ENABLE  = 1'b0;
        B_ADDR    = 16'h0000;
        repeat (3) cyc();
        for (int k = 0; k < NI; k++) begin
            check("reset_a_data", a_dout[k], 16'h0000);
            check("reset_b_valid", b_valid[k], 0);
            check("reset_busy", busy[k], 1);
        end

        // Clear with accesses attempted throughout BUSY.
        release_and_count(1'b1);
        b_read(16'h0002);
        cyc();
        idle();
        cyc();
        check("gated_write_addr2", b_dout[0], 16'h0000);
        check("gated_write_valid", b_valid[0], 1);

        for (int i = 0; i < 16; i++) begin
            a_read(16'(i));
            b_read(16'(15 - i));
            cyc();
        end
        idle();
        repeat (3) cyc();

        // Byte enables: 0x1234 then 0xABCD on the low lane only.
        a_write(16'h0005, 16'h1234, 2'b11);
        cyc();
        a_write(16'h0005, 16'hABCD, 2'b01);
        cyc();
        idle();
        b_read(16'h0005);
        cyc();
        idle();
        check("be_wr_first_a", a_dout[0], 16'h12CD);
        check("be_rd_first_a", a_dout[1], 16'h1234);
        cyc();
        check("be_b_read_lat1", b_dout[0], 16'h12CD);
        check("be_b_valid_lat1", b_valid[0], 1);
        cyc();
        check("be_b_read_lat2", b_dout[3], 16'h12CD);
        a_read(16'h0005);
        cyc();
        idle();
        repeat (3) cyc();

        // Write modes at address 3.
        a_write(16'h0003, 16'h1111, 2'b11);
        cyc();
        a_write(16'h0003, 16'h2222, 2'b11);
        cyc();
        idle();
        cyc();
        check("mode0_data", a_dout[0], 16'h2222);
        check("mode0_valid", a_valid[0], 1);
        check("mode1_data", a_dout[1], 16'h1111);
        check("mode2_data", a_dout[2], 16'h12CD);
        check("mode2_valid", a_valid[2], 0);
        cyc();
        check("mode0_lat2_data", a_dout[3], 16'h2222);
        check("mode1_lat2_data", a_dout[4], 16'h1111);
        check("mode1_lat2_valid", a_valid[4], 1);
        cyc();

        // Same-cycle collision, then the following read.
        a_write(16'h0007, 16'h0F0F, 2'b11);
        cyc();
        a_write(16'h0007, 16'h5555, 2'b11);
        b_read(16'h0007);
        cyc();
        A_ENABLE = 1'b0;
        b_read(16'h0007);
        cyc();
        idle();
        check("coll_b_lat1", b_dout[0], 16'h0F0F);
        check("coll_b_lat2_early", b_valid[3], 0);
        cyc();
        check("coll_next_lat1", b_dout[0], 16'h5555);
        check("coll_b_lat2", b_dout[3], 16'h0F0F);
        check("coll_b_lat2_valid", b_valid[3], 1);
        cyc();
        check("coll_next_lat2", b_dout[3], 16'h5555);

        // Zero byte enable: access accepted, word untouched.
        a_write(16'h0007, 16'hFFFF, 2'b00);
        cyc();
        idle();
        b_read(16'h0007);
        cyc();
        idle();
        check("be0_wr_first_a", a_dout[0], 16'h5555);
        check("be0_valid", a_valid[0], 1);
        cyc();
        check("be0_b_read", b_dout[0], 16'h5555);

        // Address wrap modulo depth.
        a_write(16'h0013, 16'h00AA, 2'b11);
        cyc();
        idle();
        b_read(16'h0003);
        cyc();
        idle();
        cyc();
        check("wrap_b_read", b_dout[0], 16'h00AA);
        cyc();

        // Back-to-back mixed traffic on both ports.
        for (int i = 0; i < 12; i++) begin
            if (i % 3 == 2) a_read(16'(i + 2));
            else a_write(16'(i + 2), 16'h3000 + 16'(i) * 16'h0111, (i % 4 == 1) ? 2'b10 : 2'b11);
            b_read(16'(i + 1));
            cyc();
        end
        idle();
        repeat (3) cyc();

        // Reads in flight when reset arrives are dropped.
        a_read(16'h0005);
        b_read(16'h0005);
        cyc();
        idle();
        RST_N = 1'b0;
        cyc();
        RST_N = 1'b1;
        for (int k = 0; k < NI; k++) check("flight_a_valid", a_valid[k], 0);
        cyc();
        check("flight_lat2_a_valid", a_valid[3], 0);
        check("flight_lat2_b_valid", b_valid[3], 0);

        // Reset again while the clear is writing address 8.
        repeat (8) cyc();
        RST_N = 1'b0;
        cyc();
        check("midclr_busy", busy[0], 1);
        check("midclr_a_data", a_dout[0], 16'h0000);
        cyc();
        release_and_count(1'b0);
        b_read(16'h000C);
        cyc();
        idle();
        cyc();
        check("reclear_addr12", b_dout[0], 16'h0000);
        check("reclear_valid", b_valid[0], 1);
        repeat (3) cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
